// File: rtl/seven_seg_scan_if.sv
// Display bus for seven_seg_scan: BCD digit/blink inputs toward the driver, anode/segment pins back out.
interface seven_seg_scan_if;
  logic [3:0] TimeTens;
  logic [3:0] TimeOnes;
  logic [3:0] ScoreTens;
  logic [3:0] ScoreOnes;
  logic       Blink;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;

  modport master (
    output TimeTens, TimeOnes, ScoreTens, ScoreOnes, Blink,
    input  An, Seg, Dp
  );

  modport slave (
    input  TimeTens, TimeOnes, ScoreTens, ScoreOnes, Blink,
    output An, Seg, Dp
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot and game-over blink.
// Optional LEADING_ZERO_BLANK_EN blanks zero tens digits of time and score.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input logic          Clk,
  input logic          Rst,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned RC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0]  BLANK_CODE = 4'hA;

  typedef enum logic {ST_ON, ST_OFF} blink_st_e;

  logic [RC_W-1:0] rc_q, rc_d;
  logic [1:0]      idx_q, idx_d;
  logic [FC_W-1:0] fc_q, fc_d;
  blink_st_e       st_q, st_d;
  logic [3:0]      tt_q, tt_d, to_q, to_d, st_snap_q, st_snap_d, so_q, so_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            digit_end_c;
  logic            frame_end_c;
  logic [3:0]      code_c;
  logic            blank_c;

  // Active-low gfedcba glyph; 15 is a dash, other non-decimal codes are blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      4'd15:   glyph = 7'b0111111;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    rc_d      = rc_q + RC_W'(1);
    idx_d     = idx_q;
    fc_d      = fc_q;
    st_d      = st_q;
    tt_d      = tt_q;
    to_d      = to_q;
    st_snap_d = st_snap_q;
    so_d      = so_q;
    code_c    = so_q;
    blank_c   = 1'b0;
    an_d      = 4'b1111;

    digit_end_c = (rc_q == RC_W'(REFRESH_DIV - 1));
    frame_end_c = digit_end_c && (idx_q == 2'd3);

    if (digit_end_c) begin
      rc_d  = '0;
      idx_d = idx_q + 2'd1;
    end

    // Snapshot on the frame boundary so a frame never mixes old and new digits.
    if (frame_end_c) begin
      tt_d      = bus.TimeTens;
      to_d      = bus.TimeOnes;
      st_snap_d = bus.ScoreTens;
      so_d      = bus.ScoreOnes;
    end

    if (!bus.Blink) begin
      st_d = ST_ON;
      fc_d = '0;
    end else if (frame_end_c) begin
      if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
        fc_d = '0;
        st_d = (st_q == ST_ON) ? ST_OFF : ST_ON;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    case (idx_q)
      2'd0: begin code_c = so_q;      an_d = 4'b1110; end
      2'd1: begin code_c = st_snap_q; an_d = 4'b1101; end
      2'd2: begin code_c = to_q;      an_d = 4'b1011; end
      default: begin code_c = tt_q;   an_d = 4'b0111; end
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    blank_c = ((idx_q == 2'd3) || (idx_q == 2'd1)) && (code_c == 4'd0);
`else
    blank_c = 1'b0;
`endif

    seg_d = blank_c ? 7'b1111111 : glyph(code_c);
    dp_d  = (idx_q != 2'd2);

    // Dropping Blink re-enables the anodes at once, without waiting for the FSM.
    if ((st_q == ST_OFF) && bus.Blink) an_d = 4'b1111;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rc_q      <= '0;
      idx_q     <= '0;
      fc_q      <= '0;
      st_q      <= ST_ON;
      tt_q      <= BLANK_CODE;
      to_q      <= BLANK_CODE;
      st_snap_q <= BLANK_CODE;
      so_q      <= BLANK_CODE;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      rc_q      <= rc_d;
      idx_q     <= idx_d;
      fc_q      <= fc_d;
      st_q      <= st_d;
      tt_q      <= tt_d;
      to_q      <= to_d;
      st_snap_q <= st_snap_d;
      so_q      <= so_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.An  = an_q;
  assign bus.Seg = seg_q;
  assign bus.Dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=4, BLINK_FRAMES=2; set LEADING_ZERO_BLANK_EN to match the DUT build.
module tb_seven_seg_scan;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] GZ_TENS = GB;
`else
  localparam logic [6:0] GZ_TENS = G0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seven_seg_scan_if ifc ();

  seven_seg_scan #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc)
  );

  always #5 Clk = ~Clk;

  task automatic check_now(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    n_checks++;
    assert (ifc.An === an && ifc.Seg === seg && ifc.Dp === dp)
    else begin
      n_fail++;
      $error("FAIL %s: An=%b Seg=%b Dp=%b, required An=%b Seg=%b Dp=%b",
             tag, ifc.An, ifc.Seg, ifc.Dp, an, seg, dp);
    end
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_now(tag, an, seg, dp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check_digit({tag, "_d0"}, 4'b1110, s0, 1'b1, 4);
    check_digit({tag, "_d1"}, 4'b1101, s1, 1'b1, 4);
    check_digit({tag, "_d2"}, 4'b1011, s2, 1'b0, 4);
    check_digit({tag, "_d3"}, 4'b0111, s3, 1'b1, 4);
  endtask

  task automatic check_off(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      n_checks++;
      assert (ifc.An === 4'b1111)
      else begin
        n_fail++;
        $error("FAIL %s: An=%b, required An=1111", tag, ifc.An);
      end
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.TimeTens  = 4'd6;
    ifc.TimeOnes  = 4'd0;
    ifc.ScoreTens = 4'd0;
    ifc.ScoreOnes = 4'd7;
    ifc.Blink     = 1'b0;

    @(negedge Clk);
    check_now("reset", 4'b1111, GB, 1'b1);
    Rst = 1'b0;

    // Frame 1 blank (snapshot reset code), frame 2 shows 6,0 / 0,7.
    check_frame("f1_blank", GB, GB, GB, GB);
    ifc.ScoreOnes = 4'd8;
    check_frame("f2_first", G7, G0, G0, G6);
    check_frame("f3_so8", G8, G0, G0, G6);

    // New codes are invisible for the frame already snapshotted.
    ifc.ScoreTens = 4'd15;
    ifc.ScoreOnes = 4'd15;
    ifc.TimeTens  = 4'd12;
    ifc.TimeOnes  = 4'd5;
    check_frame("f4_hold", G8, G0, G0, G6);
    check_frame("f5_dash", GD, GD, G5, GB);

    ifc.TimeTens  = 4'd0;
    ifc.TimeOnes  = 4'd5;
    ifc.ScoreTens = 4'd0;
    ifc.ScoreOnes = 4'd3;
    skip(16);
    check_frame("f7_zero", G3, GZ_TENS, G5, GZ_TENS);

    // Blink: two frames on, two off, two on, then off.
    ifc.Blink = 1'b1;
    check_frame("f8_blink_on", G3, GZ_TENS, G5, GZ_TENS);
    check_frame("f9_blink_on", G3, GZ_TENS, G5, GZ_TENS);
    check_off("f10_11_blink_off", 32);
    check_frame("f12_blink_on", G3, GZ_TENS, G5, GZ_TENS);
    skip(16);
    check_off("f14_blink_off", 4);
    ifc.Blink = 1'b0;
    check_digit("f14_resume_d1", 4'b1101, GZ_TENS, 1'b1, 4);
    check_digit("f14_resume_d2", 4'b1011, G5, 1'b0, 2);

    // Asynchronous reset mid digit 2.
    Rst = 1'b1;
    #1;
    check_now("async_reset", 4'b1111, GB, 1'b1);
    @(negedge Clk);
    check_now("reset_held", 4'b1111, GB, 1'b1);
    Rst = 1'b0;
    check_frame("post_rst_blank", GB, GB, GB, GB);
    check_frame("post_rst_data", G3, GZ_TENS, G5, GZ_TENS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed four-digit seven-segment driver for the Basys3 display of the Whac-A-Mole game. It sits directly downstream of the BCD converters. It takes two BCD digit pairs, 60 s countdown time and score, and drives the active-low anode and segment pins. Inputs are snapshotted once per scan frame so a digit never tears mid-frame. An optional blink mode flashes the whole display at game over.

## Interface
- REFRESH_DIV, 100000: Clk cycles each digit is lit (1 kHz digit rate / 250 Hz frame at 100 MHz); must be ≥2.
- BLINK_FRAMES, 125: scan frames per blink half-period (0.5 s at defaults); must be ≥1.
- Clk  input  1  system clock, 100 MHz.
- Rst  input  1  reset, asynchronous, active-high.
- TimeTens  input  4  BCD tens of remaining time; shown on An[3].
- TimeOnes  input  4  BCD ones of remaining time; shown on An[2].
- ScoreTens  input  4  BCD tens of score; shown on An[1].
- ScoreOnes  input  4  BCD ones of score; shown on An[0].
- Blink  input  1  high = flash display (game over).
- An  output  4  digit anodes, active-low, one-hot-low while lit.
- Seg  output  7  segments, active-low, Seg[0]=a … Seg[6]=g.
- Dp  output  1  decimal point, active-low.

## Operation
- Refresh counter rc counts 0..REFRESH_DIV-1 and wraps. Digit index idx (2 bits) increments mod 4 on the cycle rc==REFRESH_DIV-1.
- Snapshot: on the edge where idx goes 3→0, the four inputs are copied into snapshot registers. Only snapshot values are displayed.
- Glyph map, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 15 (BCD out-of-range code) = dash 0111111
  - 10–14 = blank 1111111
- Dp is low only while idx==2. This separates time from score.
- Blink FSM has two states, ON and OFF.
  - While Blink=0: state is forced to ON and the frame counter fc is cleared.
  - While Blink=1: fc increments at each frame boundary (idx 3→0). When fc reaches BLINK_FRAMES-1 it clears and the state toggles.
  - In OFF, An=1111. Seg and Dp keep their scanned values.
- Blink rising edge does not reset the state. Display starts in ON and the first toggle happens BLINK_FRAMES frames later.

## Timing
- Reset values:
  - Outputs: An=1111, Seg=1111111, Dp=1.
  - Internal: rc=0, idx=0, fc=0, blink state ON.
  - Snapshot registers: 4'hA, so the display is blank until the first snapshot.
- Reset is asynchronous. Asserting Rst mid-frame forces all of the above immediately. Scanning restarts at idx=0 on the first edge after release.
- An, Seg and Dp are registered. They reflect the idx and snapshot values from the previous cycle, a fixed one-cycle lag.
- First snapshot occurs 4·REFRESH_DIV cycles after reset release. Digit 0 of that frame appears one cycle later with the new data.
- Simultaneous snapshot and idx 3→0: digit 0 is decoded from the new snapshot.
- Input changes between snapshots are invisible until the next frame boundary.
- Each digit is lit for exactly REFRESH_DIV cycles. Exactly one An bit is low at a time, except in blink OFF and reset.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: digit 3 is blank when snapshot TimeTens==0, and digit 1 is blank when snapshot ScoreTens==0. Ones digits always display.
  - Undefined: zeros display as 0 on all digits.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_FRAMES=2.
- Reset release with Time=6,0 and Score=0,7 -> first 16 cycles An scans 1110,1101,1011,0111 with Seg=1111111. Next frame shows Seg 1111000 (7), 1000000 (0), 1000000 (0), 0000010 (6), each for 4 cycles. Dp=0 only while An=1011.
- Change ScoreOnes 7→8 mid-frame -> An[0] keeps showing 7 until the next frame boundary, then shows 0000000.
- ScoreTens=ScoreOnes=15 -> digits 1 and 0 show 0111111. Inputs of 12 show 1111111.
- With LEADING_ZERO_BLANK_EN defined and Time=0,5 -> An[3] digit shows 1111111 and An[2] shows 0010010. Undefined -> An[3] shows 1000000.
- Blink=1 held -> An active for 2 frames (32 cycles), 1111 for 2 frames, repeating. Blink→0 -> next cycle's scan resumes with An active.
- Rst pulsed mid-digit-2 -> An=1111 and Seg=1111111 asynchronously. After release, scanning restarts at An=1110 and the display stays blank for one frame.
